// File: rtl/mesi_isc_breq_arbiter_if.sv
// Bundle between the per-CPU request FIFOs, the round-robin arbiter and the
// shared broadcast FIFO. The arbiter side is the master modport.
interface mesi_isc_breq_arbiter_if #(
  parameter int CPU_NUM      = 4,
  parameter int CPU_ID_WIDTH = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int CREDIT_WIDTH = 3
);
  logic [CPU_NUM*DATA_WIDTH-1:0]        fifo_data_i;
  logic [CPU_NUM-1:0]                   fifo_empty_i;
  logic [CPU_NUM-1:0]                   fifo_rd_o;
  logic                                 dest_rd_i;
  logic                                 wr_o;
  logic [DATA_WIDTH+CPU_ID_WIDTH-1:0]   data_o;
  logic [CREDIT_WIDTH-1:0]              credits_o;
  logic                                 err_credit_o;

  modport master (
    input  fifo_data_i, fifo_empty_i, dest_rd_i,
    output fifo_rd_o, wr_o, data_o, credits_o, err_credit_o
  );

  modport slave (
    output fifo_data_i, fifo_empty_i, dest_rd_i,
    input  fifo_rd_o, wr_o, data_o, credits_o, err_credit_o
  );
endinterface

// File: rtl/mesi_isc_breq_arbiter.sv
// Round-robin arbiter from the per-CPU broadcast-request FIFOs into the shared
// broadcast FIFO, with a local credit counter guarding destination space.
module mesi_isc_breq_arbiter #(
  parameter int CPU_NUM        = 4,
  parameter int CPU_ID_WIDTH   = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int DEST_FIFO_SIZE = 4,
  parameter int CREDIT_WIDTH   = 3
) (
  input logic                     clk,
  input logic                     rst,
  mesi_isc_breq_arbiter_if.master bus
);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(DEST_FIFO_SIZE);

  logic [CPU_ID_WIDTH-1:0]              rr_ptr;
  logic [CPU_ID_WIDTH-1:0]              win;
  logic [CREDIT_WIDTH-1:0]              credits;
  logic [CPU_NUM-1:0]                   req;
  logic                                 any_req;
  logic                                 issue;
  logic [DATA_WIDTH-1:0]                sel_data;
  logic                                 wr_q;
  logic [DATA_WIDTH+CPU_ID_WIDTH-1:0]   data_q;
  logic                                 err_q;

  assign req = ~bus.fifo_empty_i;

  // Walk the ring backwards so the first requester at/after rr_ptr wins last.
  always_comb begin
    win     = rr_ptr;
    any_req = 1'b0;
    for (int k = CPU_NUM - 1; k >= 0; k--) begin
      if (req[rr_ptr + CPU_ID_WIDTH'(k)]) begin
        win     = rr_ptr + CPU_ID_WIDTH'(k);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CPU_NUM; i++) begin
      if (win == CPU_ID_WIDTH'(i))
        sel_data = bus.fifo_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Gating with rst keeps pops quiet while the source FIFOs are being cleared.
  assign issue = any_req && (credits != '0) && !rst;

  always_comb begin
    bus.fifo_rd_o = '0;
    if (issue)
      bus.fifo_rd_o = CPU_NUM'(1) << win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      credits <= CREDIT_MAX;
      wr_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (issue) begin
        wr_q   <= 1'b1;
        data_q <= {win, sel_data};
        rr_ptr <= win + CPU_ID_WIDTH'(1);
      end else begin
        wr_q   <= 1'b0;
      end

      // A return while already full is a consumer protocol error; never count past full.
      if (bus.dest_rd_i && credits == CREDIT_MAX)
        err_q <= 1'b1;

      if (issue && !bus.dest_rd_i)
        credits <= credits - CREDIT_WIDTH'(1);
      else if (!issue && bus.dest_rd_i && credits != CREDIT_MAX)
        credits <= credits + CREDIT_WIDTH'(1);
    end
  end

  assign bus.wr_o         = wr_q;
  assign bus.data_o       = data_q;
  assign bus.credits_o    = credits;
  assign bus.err_credit_o = err_q;
endmodule

// File: tb/tb_mesi_isc_breq_arbiter.sv
// Directed bench for the broadcast-request arbiter: behavioural source FIFOs,
// a reference grant/credit model and a scoreboard of expected broadcast writes.
module tb_mesi_isc_breq_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mesi_isc_breq_arbiter_if #(.CPU_NUM(4), .CPU_ID_WIDTH(2), .DATA_WIDTH(32), .CREDIT_WIDTH(3)) bus ();

  mesi_isc_breq_arbiter #(
    .CPU_NUM(4), .CPU_ID_WIDTH(2), .DATA_WIDTH(32), .DEST_FIFO_SIZE(4), .CREDIT_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] srcq [4][$];
  logic [33:0] sb [$];
  int          m_rr;
  int          m_cred;
  logic        m_err;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      bus.fifo_empty_i[i] = (srcq[i].size() == 0);
      bus.fifo_data_i[i*32 +: 32] = (srcq[i].size() != 0) ? srcq[i][0] : 32'h0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) srcq[i].delete();
    sb.delete();
    m_rr   = 0;
    m_cred = 4;
    m_err  = 1'b0;
  endtask

  task automatic fill_all(input int n, input logic [7:0] tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < n; j++)
        srcq[i].push_back({tag, 8'(i), 16'(j)});
  endtask

  // One clock: check registered outputs and the grant at the falling edge,
  // then advance the reference model across the rising edge.
  task automatic cycle(input logic drd);
    int         w;
    logic       issue;
    logic [3:0] exp_rd;
    logic [33:0] exp_d;
    bus.dest_rd_i = drd;
    drive_src();
    @(negedge clk);
    if (sb.size() != 0) begin
      exp_d = sb.pop_front();
      check("wr_o", 64'(bus.wr_o), 64'd1);
      check("data_o", 64'(bus.data_o), 64'(exp_d));
    end else begin
      check("wr_o_idle", 64'(bus.wr_o), 64'd0);
    end
    check("credits_o", 64'(bus.credits_o), 64'(m_cred));
    check("err_credit_o", 64'(bus.err_credit_o), 64'(m_err));
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && srcq[(m_rr + k) % 4].size() != 0) w = (m_rr + k) % 4;
    issue  = (w >= 0) && (m_cred != 0);
    exp_rd = issue ? (4'b0001 << w) : 4'b0000;
    check("fifo_rd_o", 64'(bus.fifo_rd_o), 64'(exp_rd));
    if (issue) sb.push_back({2'(w), srcq[w][0]});
    @(posedge clk);
    #1;
    if (drd && m_cred == 4) m_err = 1'b1;
    if (!(drd && !issue && m_cred == 4)) m_cred = m_cred - int'(issue) + int'(drd);
    if (issue) begin
      m_rr = (w + 1) % 4;
      void'(srcq[w].pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dest_rd_i = 1'b0;
    model_reset();
    drive_src();
    #12;
    check("rst_wr_o", 64'(bus.wr_o), 64'd0);
    check("rst_data_o", 64'(bus.data_o), 64'd0);
    check("rst_fifo_rd_o", 64'(bus.fifo_rd_o), 64'd0);
    check("rst_credits_o", 64'(bus.credits_o), 64'd4);
    check("rst_err", 64'(bus.err_credit_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0);

    // Single source on CPU2, then CPU1 and CPU3 pending: pointer now at 3 picks CPU3 first
    srcq[2].push_back(32'hA5A5_0001);
    cycle(1'b0);
    srcq[1].push_back(32'h1111_0001);
    srcq[3].push_back(32'h3333_0001);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);

    // Credit error at full credits; sticky
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);

    // Fairness with continuous returns
    fill_all(3, 8'hF0);
    for (int i = 0; i < 12; i++) cycle(1'b1);
    cycle(1'b0);

    // Exhaustion, single return, then simultaneous issue and return at credit 1
    fill_all(4, 8'hE0);
    for (int i = 0; i < 6; i++) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);

    // Mid-stream reset with sources still non-empty
    cycle(1'b1);
    cycle(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_wr_o", 64'(bus.wr_o), 64'd0);
    check("midrst_fifo_rd_o", 64'(bus.fifo_rd_o), 64'd0);
    check("midrst_data_o", 64'(bus.data_o), 64'd0);
    check("midrst_credits_o", 64'(bus.credits_o), 64'd4);
    check("midrst_err", 64'(bus.err_credit_o), 64'd0);
    model_reset();
    drive_src();
    @(posedge clk); #1;
    rst = 1'b0;
    fill_all(2, 8'hD0);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
